// File: rtl/bus_rx_pkg.sv
// -----------------------------------------------------------------------------
// bus_rx_pkg
// Shared definitions for the shared-bus receiver:
//   - rx_state_e   : receiver FSM state encoding
//   - PAR_MAX_W    : widest data word the parity helper accepts
//   - even_parity_ok() : 1 when {par, data} has an even number of ones
//   - tmo_cnt_w()  : width of the ack wait counter for a given TIMEOUT
// -----------------------------------------------------------------------------
package bus_rx_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACK    = 2'd2
  } rx_state_e;

  // Callers zero-extend their data to this width; zeros do not change parity.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_parity_ok(input logic [PAR_MAX_W-1:0] data,
                                          input logic                 par);
    return ~(^{par, data});
  endfunction

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_rx_fifo.sv
// -----------------------------------------------------------------------------
// bus_rx_fifo
// Synchronous FIFO without fall-through: a word pushed at an edge shows up on
// rdata_o/valid_o from that edge onward (i.e. in the cycle after the push).
// The head word is held in a register so rdata_o keeps its last value when
// the FIFO runs empty.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i/wdata_i write request and data (ignored when full)
//   pop_i          read request (ignored when empty)
//   full_o/empty_o occupancy flags from registered pointers
//   count_o        occupancy, 0..DEPTH
//   rdata_o        head word (registered)
//   valid_o        FIFO non-empty (registered)
// -----------------------------------------------------------------------------
module bus_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W-1:0]             rdata_o,
  output logic                     valid_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [AW:0]  cnt_d;
  logic [W-1:0] head_q, head_d;
  logic         valid_q, valid_d;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit: full when only that bit differs.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign rdata_o = head_q;
  assign valid_o = valid_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and next head word.
  always_comb begin
    wr_d    = wr_q + (AW + 1)'(do_push);
    rd_d    = rd_q + (AW + 1)'(do_pop);
    cnt_d   = wr_d - rd_d;
    valid_d = (cnt_d != {(AW + 1){1'b0}});
    if (cnt_d == {(AW + 1){1'b0}}) begin
      head_d = head_q;
    end else if (do_push && (rd_d == wr_q)) begin
      // New head is the word being written right now, not yet in memory.
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  // Storage write; entries need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Pointer, head and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= {(AW + 1){1'b0}};
      rd_q    <= {(AW + 1){1'b0}};
      head_q  <= {W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/shared_bus_receiver.sv
// -----------------------------------------------------------------------------
// shared_bus_receiver
// Listening end of a shared tri-state bus. Captures one word per four-phase
// req/ack handshake, drops words with bad even parity (perr pulse), and
// queues good words in a FIFO read through a valid/ready interface.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus_data, bus_par     resolved bus word and its even-parity bit
//   bus_req / bus_ack     four-phase handshake (bus_ack registered)
//   out_data, out_valid   FIFO head and non-empty flag
//   out_ready             consumer accept
//   count                 FIFO occupancy
//   perr                  one-cycle pulse per dropped (bad parity) word
//   timeout_err           sticky: peer held req too long after ack
// -----------------------------------------------------------------------------
module shared_bus_receiver
  import bus_rx_pkg::*;
#(
  parameter int W       = 8,   // must not exceed PAR_MAX_W
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           bus_data,
  input  logic                   bus_par,
  input  logic                   bus_req,
  output logic                   bus_ack,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   perr,
  output logic                   timeout_err
);

  localparam int             TW       = tmo_cnt_w(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  rx_state_e     state_q;
  logic          ack_q;
  logic          perr_q;
  logic          tmo_q;
  logic [TW-1:0] wait_q;

  logic full, empty;
  logic capture, par_ok, push, pop;

  // The bus is only looked at on the IDLE capture edge; Z/X elsewhere is moot.
  assign par_ok  = even_parity_ok(PAR_MAX_W'(bus_data), bus_par);
  assign capture = (state_q == ST_IDLE) & bus_req & ~full;
  assign push    = capture & par_ok;
  assign pop     = out_ready & ~empty;

  assign bus_ack     = ack_q;
  assign perr        = perr_q;
  assign timeout_err = tmo_q;

  bus_rx_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus_data),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .rdata_o (out_data),
    .valid_o (out_valid)
  );

  // Handshake FSM with registered ack, parity-error pulse and timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESYNC;
      ack_q   <= 1'b0;
      perr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wait_q  <= {TW{1'b0}};
    end else begin
      perr_q <= 1'b0;
      case (state_q)
        ST_RESYNC: begin
          // Let any transfer that straddled reset finish before listening.
          ack_q <= 1'b0;
          if (!bus_req) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RESYNC;
          end
        end
        ST_IDLE: begin
          if (capture) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            wait_q  <= {TW{1'b0}};
            perr_q  <= ~par_ok;
          end else begin
            ack_q <= 1'b0;
          end
        end
        ST_ACK: begin
          if (!bus_req) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end else if (wait_q == TMO_LAST) begin
            // This is the TIMEOUT-th ACK cycle with req still high.
            state_q <= ST_RESYNC;
            ack_q   <= 1'b0;
            tmo_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + {{(TW - 1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= ST_RESYNC;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
